// File: rtl/myproject_mul_acc_pipe.sv
// rtl/myproject_mul_acc_pipe.sv - pipelined multiply-accumulate with per-group dot-product result
//
// Multiplies s_din0 x s_din1 (each operand optionally two's complement),
// carries the product through NUM_STAGE register stages and sums products
// until an s_last-tagged element leaves the tail stage, then presents the
// group sum on m_dout with a sticky overflow flag on m_ovf.
//
// Ports:
//   ap_clk, ap_rst_n            clock (rising edge), asynchronous active-low reset
//   s_valid/s_ready             input element handshake
//   s_din0, s_din1, s_last      operands and end-of-group tag
//   m_valid/m_ready             result handshake
//   m_dout, m_ovf               group sum (modulo 2^ACC_WIDTH) and wrap flag
module myproject_mul_acc_pipe #(
    parameter int DIN0_WIDTH = 24,
    parameter int DIN1_WIDTH = 18,
    parameter int NUM_STAGE  = 2,
    parameter int ACC_WIDTH  = 48,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DIN0_WIDTH-1:0] s_din0,
    input  logic [DIN1_WIDTH-1:0] s_din1,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ACC_WIDTH-1:0]  m_dout,
    output logic                  m_ovf
);

    localparam int P         = DIN0_WIDTH + DIN1_WIDTH;
    localparam bit SIGN_MODE = (SIGNED0 != 0) || (SIGNED1 != 0);

    logic                 adv;
    logic                 ext0;
    logic                 ext1;
    logic [P-1:0]         op0_w;
    logic [P-1:0]         op1_w;
    logic [P-1:0]         prod_w;

    logic [P-1:0]         prod_q [NUM_STAGE];
    logic [NUM_STAGE-1:0] vld_q;
    logic [NUM_STAGE-1:0] last_q;

    logic [P-1:0]         tail_prod;
    logic                 tail_vld;
    logic                 tail_last;
    logic [ACC_WIDTH-1:0] prod_ext;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 first_q, first_d;
    logic                 m_valid_q, m_valid_d;
    logic [ACC_WIDTH-1:0] m_dout_q, m_dout_d;
    logic                 m_ovf_q, m_ovf_d;

    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   sum_full;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic                 add_ovf;
    logic                 ovf_sum;

    // A stalled result blocks the whole pipe; a consumed or absent one frees it.
    assign adv     = !m_valid_q || m_ready;
    assign s_ready = adv;

    // Extending each operand to the full product width with its own sign
    // (or zero) makes the low P bits of a plain multiply equal to the signed
    // product of the one-bit-extended operands.
    assign ext0   = (SIGNED0 != 0) && s_din0[DIN0_WIDTH-1];
    assign ext1   = (SIGNED1 != 0) && s_din1[DIN1_WIDTH-1];
    assign op0_w  = {{(P-DIN0_WIDTH){ext0}}, s_din0};
    assign op1_w  = {{(P-DIN1_WIDTH){ext1}}, s_din1};
    assign prod_w = op0_w * op1_w;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                prod_q[i] <= '0;
            end
            vld_q  <= '0;
            last_q <= '0;
        end else if (adv) begin
            prod_q[0] <= prod_w;
            vld_q[0]  <= s_valid;
            last_q[0] <= s_last;
            for (int i = 1; i < NUM_STAGE; i++) begin
                prod_q[i] <= prod_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
            end
        end
    end

    assign tail_prod = prod_q[NUM_STAGE-1];
    assign tail_vld  = vld_q[NUM_STAGE-1];
    assign tail_last = last_q[NUM_STAGE-1];

    if (ACC_WIDTH > P) begin : g_ext
        assign prod_ext = {{(ACC_WIDTH-P){SIGN_MODE & tail_prod[P-1]}}, tail_prod};
    end else begin : g_noext
        assign prod_ext = tail_prod;
    end

    always_comb begin
        acc_base = first_q ? '0 : acc_q;
        sum_full = {1'b0, acc_base} + {1'b0, prod_ext};
        acc_sum  = sum_full[ACC_WIDTH-1:0];
        if (SIGN_MODE) begin
            add_ovf = (acc_base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (acc_sum[ACC_WIDTH-1] != acc_base[ACC_WIDTH-1]);
        end else begin
            add_ovf = sum_full[ACC_WIDTH];
        end
        ovf_sum = (!first_q && ovf_q) || add_ovf;
    end

    always_comb begin
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        first_d   = first_q;
        m_valid_d = m_valid_q;
        m_dout_d  = m_dout_q;
        m_ovf_d   = m_ovf_q;
        if (adv) begin
            m_valid_d = 1'b0;
            if (tail_vld) begin
                if (tail_last) begin
                    m_dout_d  = acc_sum;
                    m_ovf_d   = ovf_sum;
                    m_valid_d = 1'b1;
                    acc_d     = '0;
                    ovf_d     = 1'b0;
                    first_d   = 1'b1;
                end else begin
                    acc_d   = acc_sum;
                    ovf_d   = ovf_sum;
                    first_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            first_q   <= 1'b1;
            m_valid_q <= 1'b0;
            m_dout_q  <= '0;
            m_ovf_q   <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            first_q   <= first_d;
            m_valid_q <= m_valid_d;
            m_dout_q  <= m_dout_d;
            m_ovf_q   <= m_ovf_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_dout  = m_dout_q;
    assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_myproject_mul_acc_pipe.sv
// tb/tb_myproject_mul_acc_pipe.sv - self-checking bench for myproject_mul_acc_pipe
module tb_myproject_mul_acc_pipe;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // a: defaults (24x18, 2 stages, 48-bit, unsigned)
    logic        a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_ovf;
    logic [23:0] a_s_din0;
    logic [17:0] a_s_din1;
    logic [47:0] a_m_dout;
    // b: signed 24x18, 3 stages, minimum accumulator width 42
    logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_ovf;
    logic [23:0] b_s_din0;
    logic [17:0] b_s_din1;
    logic [41:0] b_m_dout;
    // c: unsigned 4x4, 1 stage, 9-bit accumulator
    logic        c_s_valid, c_s_ready, c_s_last, c_m_valid, c_m_ready, c_m_ovf;
    logic [3:0]  c_s_din0;
    logic [3:0]  c_s_din1;
    logic [8:0]  c_m_dout;

    myproject_mul_acc_pipe dut_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_din0(a_s_din0), .s_din1(a_s_din1),
        .s_last(a_s_last), .m_valid(a_m_valid), .m_ready(a_m_ready), .m_dout(a_m_dout),
        .m_ovf(a_m_ovf)
    );

    myproject_mul_acc_pipe #(
        .DIN0_WIDTH(24), .DIN1_WIDTH(18), .NUM_STAGE(3), .ACC_WIDTH(42),
        .SIGNED0(1), .SIGNED1(1)
    ) dut_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_din0(b_s_din0), .s_din1(b_s_din1),
        .s_last(b_s_last), .m_valid(b_m_valid), .m_ready(b_m_ready), .m_dout(b_m_dout),
        .m_ovf(b_m_ovf)
    );

    myproject_mul_acc_pipe #(
        .DIN0_WIDTH(4), .DIN1_WIDTH(4), .NUM_STAGE(1), .ACC_WIDTH(9),
        .SIGNED0(0), .SIGNED1(0)
    ) dut_c (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s_valid(c_s_valid), .s_ready(c_s_ready), .s_din0(c_s_din0), .s_din1(c_s_din1),
        .s_last(c_s_last), .m_valid(c_m_valid), .m_ready(c_m_ready), .m_dout(c_m_dout),
        .m_ovf(c_m_ovf)
    );

    typedef struct {
        longint d0;
        longint d1;
        bit     last;
        int     idle;
    } elem_t;

    typedef struct {
        logic [63:0] dout;
        logic        ovf;
    } res_t;

    elem_t in_q[$];
    res_t  out_q[$];
    res_t  exp_q[$];

    int W0[3] = '{24, 24, 4};
    int W1[3] = '{18, 18, 4};
    int AW[3] = '{48, 42, 9};
    bit SG[3] = '{1'b0, 1'b1, 1'b0};

    function automatic longint opval(longint raw, int width, bit sgn);
        longint v;
        v = raw & ((longint'(1) << width) - 1);
        if (sgn && (((v >> (width - 1)) & 1) == 1)) v = v - (longint'(1) << width);
        return v;
    endfunction

    function automatic longint rnd_op(int width);
        longint m;
        m = (longint'(1) << width) - 1;
        case ($urandom_range(0, 3))
            0:       return m;
            1:       return longint'(1) << (width - 1);
            default: return longint'($urandom) & m;
        endcase
    endfunction

    // Reference: integer dot products, wrapped into the accumulator range,
    // overflow sticky across the group.
    task automatic model_build(input int w);
        longint acc, p, t, lo, hi, span;
        bit     ovf, first;
        exp_q.delete();
        acc = 0; ovf = 0; first = 1;
        span = longint'(1) << AW[w];
        lo = SG[w] ? -(span / 2) : 0;
        hi = SG[w] ? (span / 2) - 1 : span - 1;
        foreach (in_q[i]) begin
            p = opval(in_q[i].d0, W0[w], SG[w]) * opval(in_q[i].d1, W1[w], SG[w]);
            t = (first ? 0 : acc) + p;
            ovf = (first ? 1'b0 : ovf) | (t < lo || t > hi);
            if (t > hi) t = t - span;
            else if (t < lo) t = t + span;
            acc = t;
            first = 0;
            if (in_q[i].last) begin
                exp_q.push_back('{dout: 64'(acc & (span - 1)), ovf: ovf});
                first = 1;
            end
        end
    endtask

    task automatic gen_stream(input int w, input int n, input int idle_max);
        elem_t e;
        in_q.delete();
        for (int i = 0; i < n; i++) begin
            e.d0   = rnd_op(W0[w]);
            e.d1   = rnd_op(W1[w]);
            e.last = (i == n - 1) || ($urandom_range(0, 2) == 0);
            e.idle = $urandom_range(0, idle_max);
            in_q.push_back(e);
        end
    endtask

    task automatic drive(input int w, input bit v, input elem_t e, input bit mr);
        case (w)
            0: begin a_s_valid = v; a_s_din0 = e.d0[23:0]; a_s_din1 = e.d1[17:0]; a_s_last = e.last; a_m_ready = mr; end
            1: begin b_s_valid = v; b_s_din0 = e.d0[23:0]; b_s_din1 = e.d1[17:0]; b_s_last = e.last; b_m_ready = mr; end
            default: begin c_s_valid = v; c_s_din0 = e.d0[3:0]; c_s_din1 = e.d1[3:0]; c_s_last = e.last; c_m_ready = mr; end
        endcase
    endtask

    task automatic sample(input int w, output bit sr, output bit mv, output logic [63:0] d, output bit ov);
        case (w)
            0: begin sr = a_s_ready; mv = a_m_valid; d = 64'(a_m_dout); ov = a_m_ovf; end
            1: begin sr = b_s_ready; mv = b_m_valid; d = 64'(b_m_dout); ov = b_m_ovf; end
            default: begin sr = c_s_ready; mv = c_m_valid; d = 64'(c_m_dout); ov = c_m_ovf; end
        endcase
    endtask

    // Streams in_q into DUT w with random valid/ready, collects results in out_q.
    task automatic run_stream(input int w, input int vpct, input int rpct, input int budget);
        int          cyc, drain;
        bit          v, mr, sr, mv, ov, p_stall;
        logic [63:0] d, p_d;
        elem_t       e;
        cyc = 0; drain = 0; p_stall = 0; p_d = '0;
        out_q.delete();
        while (cyc < budget && drain < 12) begin
            e = '{d0: 0, d1: 0, last: 0, idle: 0};
            v = 0;
            if (in_q.size() > 0) begin
                e = in_q[0];
                if (e.idle > 0) begin
                    e.idle--;
                    in_q[0] = e;
                end else begin
                    v = ($urandom_range(0, 99) < vpct);
                end
            end
            mr = ($urandom_range(0, 99) < rpct);
            drive(w, v, e, mr);
            #1;
            sample(w, sr, mv, d, ov);
            checks++;
            if (sr !== (!mv || mr)) begin
                errors++;
                $display("FAIL s_ready_adv dut%0d: s_ready=%0b required %0b", w, sr, (!mv || mr));
            end
            if (p_stall) begin
                checks++;
                if (!mv || d !== p_d) begin
                    errors++;
                    $display("FAIL stall_hold dut%0d: m_valid=%0b m_dout=%0h required 1 / %0h", w, mv, d, p_d);
                end
            end
            if (mv && mr) out_q.push_back('{dout: d, ovf: ov});
            if (v && sr) void'(in_q.pop_front());
            p_stall = mv && !mr;
            p_d = d;
            if (in_q.size() == 0 && !mv) drain++;
            else drain = 0;
            @(posedge ap_clk); #1;
            cyc++;
        end
        checks++;
        if (cyc >= budget) begin
            errors++;
            $display("FAIL stream_timeout dut%0d: %0d cycles used, budget %0d", w, cyc, budget);
        end
        e = '{d0: 0, d1: 0, last: 0, idle: 0};
        drive(w, 0, e, 1);
    endtask

    task automatic compare_results(input string name);
        int n;
        checks++;
        if (out_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d results required %0d", name, out_q.size(), exp_q.size());
        end
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (out_q[i].dout !== exp_q[i].dout || out_q[i].ovf !== exp_q[i].ovf) begin
                errors++;
                $display("FAIL %s[%0d]: dout=%0h ovf=%0b required dout=%0h ovf=%0b",
                         name, i, out_q[i].dout, out_q[i].ovf, exp_q[i].dout, exp_q[i].ovf);
            end
        end
    endtask

    task automatic wait_valid_a(input int limit, output int n);
        n = 0;
        while (!a_m_valid && n < limit) begin
            @(posedge ap_clk); #1;
            n++;
        end
        checks++;
        if (!a_m_valid) begin
            errors++;
            $display("FAIL wait_m_valid: m_valid=0 after %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        elem_t e;
        e = '{d0: 0, d1: 0, last: 0, idle: 0};
        for (int w = 0; w < 3; w++) drive(w, 0, e, 1);
        ap_rst_n = 1'b1;
        #1 ap_rst_n = 1'b0;
        #2;
        checks += 8;
        if (a_s_ready !== 1'b1) begin errors++; $display("FAIL reset_a_s_ready: %0b required 1", a_s_ready); end
        if (a_m_valid !== 1'b0) begin errors++; $display("FAIL reset_a_m_valid: %0b required 0", a_m_valid); end
        if (a_m_dout !== 48'd0) begin errors++; $display("FAIL reset_a_m_dout: %0h required 0", a_m_dout); end
        if (a_m_ovf !== 1'b0)   begin errors++; $display("FAIL reset_a_m_ovf: %0b required 0", a_m_ovf); end
        if (c_s_ready !== 1'b1) begin errors++; $display("FAIL reset_c_s_ready: %0b required 1", c_s_ready); end
        if (c_m_valid !== 1'b0) begin errors++; $display("FAIL reset_c_m_valid: %0b required 0", c_m_valid); end
        if (b_m_dout !== 42'd0) begin errors++; $display("FAIL reset_b_m_dout: %0h required 0", b_m_dout); end
        if (b_m_valid !== 1'b0) begin errors++; $display("FAIL reset_b_m_valid: %0b required 0", b_m_valid); end
        repeat (2) @(posedge ap_clk);
        #3 ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
    endtask

    task automatic test_latency();
        elem_t e;
        int    n;
        e = '{d0: 64'hFFFFFF, d1: 64'h3FFFF, last: 1, idle: 0};
        drive(0, 1, e, 1);
        #1;
        checks++;
        if (a_s_ready !== 1'b1) begin errors++; $display("FAIL latency_accept: s_ready=%0b required 1", a_s_ready); end
        @(posedge ap_clk); #1;
        drive(0, 0, e, 1);
        n = 1;
        while (!a_m_valid && n < 10) begin
            @(posedge ap_clk); #1;
            n++;
        end
        checks += 3;
        if (n != 3) begin errors++; $display("FAIL latency_cycles: %0d required 3", n); end
        if (a_m_dout !== 48'h03FF_FEFC_0001) begin errors++; $display("FAIL latency_dout: %0h required 3fffefc0001", a_m_dout); end
        if (a_m_ovf !== 1'b0) begin errors++; $display("FAIL latency_ovf: %0b required 0", a_m_ovf); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_back_to_back();
        int first_c, last_c;
        bit sr, mv, ov;
        logic [63:0] d;
        elem_t e;
        gen_stream(0, 8, 0);
        foreach (in_q[i]) in_q[i].last = 1;
        model_build(0);
        out_q.delete();
        first_c = -1; last_c = -1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            e = (cyc < 8) ? in_q[cyc] : '{d0: 0, d1: 0, last: 0, idle: 0};
            drive(0, cyc < 8, e, 1);
            #1;
            sample(0, sr, mv, d, ov);
            if (mv) begin
                out_q.push_back('{dout: d, ovf: ov});
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end
            @(posedge ap_clk); #1;
        end
        checks += 2;
        if (first_c != 3) begin errors++; $display("FAIL b2b_first: first result at %0d required 3", first_c); end
        if (last_c - first_c + 1 != 8) begin errors++; $display("FAIL b2b_contiguous: span %0d required 8", last_c - first_c + 1); end
        compare_results("b2b");
    endtask

    task automatic test_backpressure();
        elem_t e1, e2;
        int    n;
        e1 = '{d0: 2, d1: 3, last: 1, idle: 0};
        e2 = '{d0: 4, d1: 5, last: 1, idle: 0};
        drive(0, 1, e1, 0);
        @(posedge ap_clk); #1;
        drive(0, 1, e2, 0);
        @(posedge ap_clk); #1;
        drive(0, 0, e2, 0);
        wait_valid_a(8, n);
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (a_s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready[%0d]: %0b required 0", k, a_s_ready); end
            if (a_m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid[%0d]: %0b required 1", k, a_m_valid); end
            if (a_m_dout !== 48'd6) begin errors++; $display("FAIL bp_hold[%0d]: %0d required 6", k, a_m_dout); end
            @(posedge ap_clk); #1;
        end
        drive(0, 0, e2, 1);
        #1;
        checks += 2;
        if (a_s_ready !== 1'b1 || a_m_valid !== 1'b1) begin errors++; $display("FAIL bp_release: s_ready=%0b m_valid=%0b required 1/1", a_s_ready, a_m_valid); end
        if (a_m_dout !== 48'd6) begin errors++; $display("FAIL bp_first: %0d required 6", a_m_dout); end
        @(posedge ap_clk); #1;
        checks += 2;
        if (a_m_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid: %0b required 1", a_m_valid); end
        if (a_m_dout !== 48'd20) begin errors++; $display("FAIL bp_second: %0d required 20", a_m_dout); end
        @(posedge ap_clk); #1;
        checks++;
        if (a_m_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: m_valid=%0b required 0", a_m_valid); end
    endtask

    task automatic test_reset_mid_group();
        elem_t e;
        int    n;
        e = '{d0: 3, d1: 3, last: 0, idle: 0};
        drive(0, 1, e, 1);
        @(posedge ap_clk); #1;
        e = '{d0: 2, d1: 2, last: 0, idle: 0};
        drive(0, 1, e, 1);
        @(posedge ap_clk); #1;
        drive(0, 0, e, 1);
        #2 ap_rst_n = 1'b0;
        #1;
        checks += 4;
        if (a_m_dout !== 48'd0) begin errors++; $display("FAIL rst_mid_dout: %0h required 0", a_m_dout); end
        if (a_m_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: %0b required 0", a_m_valid); end
        if (a_m_ovf !== 1'b0)   begin errors++; $display("FAIL rst_mid_ovf: %0b required 0", a_m_ovf); end
        if (a_s_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: %0b required 1", a_s_ready); end
        @(posedge ap_clk);
        #3 ap_rst_n = 1'b1;
        @(posedge ap_clk); #1;
        e = '{d0: 7, d1: 6, last: 1, idle: 0};
        drive(0, 1, e, 1);
        @(posedge ap_clk); #1;
        drive(0, 0, e, 1);
        wait_valid_a(8, n);
        checks += 2;
        if (a_m_dout !== 48'd42) begin errors++; $display("FAIL rst_mid_result: %0d required 42", a_m_dout); end
        if (a_m_ovf !== 1'b0)    begin errors++; $display("FAIL rst_mid_result_ovf: %0b required 0", a_m_ovf); end
        @(posedge ap_clk); #1;
    endtask

    task automatic test_random_unsigned();
        gen_stream(0, 60, 2);
        model_build(0);
        run_stream(0, 75, 65, 4000);
        compare_results("rand_unsigned");
    endtask

    task automatic test_signed();
        in_q.delete();
        in_q.push_back('{d0: -2, d1: 3, last: 0, idle: 0});
        in_q.push_back('{d0: 4, d1: 5, last: 0, idle: 1});
        in_q.push_back('{d0: -1, d1: -1, last: 1, idle: 0});
        run_stream(1, 100, 100, 200);
        checks++;
        if (out_q.size() != 1) begin
            errors++;
            $display("FAIL signed_count: %0d results required 1", out_q.size());
        end else begin
            checks++;
            if (out_q[0].dout !== 64'd15 || out_q[0].ovf !== 1'b0) begin
                errors++;
                $display("FAIL signed_sum: dout=%0d ovf=%0b required 15/0", out_q[0].dout, out_q[0].ovf);
            end
        end
    endtask

    task automatic test_random_signed();
        gen_stream(1, 60, 2);
        model_build(1);
        run_stream(1, 80, 70, 4000);
        compare_results("rand_signed");
    endtask

    task automatic test_overflow();
        in_q.delete();
        in_q.push_back('{d0: 15, d1: 15, last: 0, idle: 0});
        in_q.push_back('{d0: 15, d1: 15, last: 0, idle: 0});
        in_q.push_back('{d0: 15, d1: 15, last: 1, idle: 0});
        in_q.push_back('{d0: 1, d1: 1, last: 1, idle: 0});
        run_stream(2, 100, 100, 200);
        checks++;
        if (out_q.size() != 2) begin
            errors++;
            $display("FAIL ovf_count: %0d results required 2", out_q.size());
        end else begin
            checks += 2;
            if (out_q[0].dout !== 64'd163 || out_q[0].ovf !== 1'b1) begin
                errors++;
                $display("FAIL ovf_wrap: dout=%0d ovf=%0b required 163/1", out_q[0].dout, out_q[0].ovf);
            end
            if (out_q[1].dout !== 64'd1 || out_q[1].ovf !== 1'b0) begin
                errors++;
                $display("FAIL ovf_sticky_clear: dout=%0d ovf=%0b required 1/0", out_q[1].dout, out_q[1].ovf);
            end
        end
    endtask

    task automatic test_random_narrow();
        gen_stream(2, 80, 1);
        model_build(2);
        run_stream(2, 70, 60, 4000);
        compare_results("rand_narrow");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_group();
        test_random_unsigned();
        test_signed();
        test_random_signed();
        test_overflow();
        test_random_narrow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/myproject_mul_acc_pipe.md
Name: myproject_mul_acc_pipe

Overview:
- Pipelined, parametrised multiply-accumulate block for the generated CNN datapath.
- Successor to the fixed-width single-cycle multipliers.
- Adds per-operand signedness, a configurable multiplier pipeline depth, a valid/ready handshake with backpressure, and a dot-product accumulator.
- The accumulator sums products until a `last`-tagged element arrives, then emits one result.

Parameters:
- DIN0_WIDTH, 24, operand 0 width.
- DIN1_WIDTH, 18, operand 1 width.
- NUM_STAGE, 2, multiplier pipeline register stages; must be >= 1.
- ACC_WIDTH, 48, accumulator/result width; must be >= DIN0_WIDTH+DIN1_WIDTH.
- SIGNED0, 0, 1 = din0 is two's complement, 0 = unsigned.
- SIGNED1, 0, 1 = din1 is two's complement, 0 = unsigned.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input element valid.
- s_ready  out  1  block can accept an element this cycle.
- s_din0  in  DIN0_WIDTH  operand 0.
- s_din1  in  DIN1_WIDTH  operand 1.
- s_last  in  1  element is the final element of its accumulation group.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_dout  out  ACC_WIDTH  accumulated group sum.
- m_ovf  out  1  group accumulation overflowed ACC_WIDTH; qualified by m_valid.

Behaviour:
- Reset: on ap_rst_n low, immediately and independent of clock:
  - all pipeline valid bits = 0, accumulator = 0, first-flag = 1;
  - m_valid = 0, m_dout = 0, m_ovf = 0.
  - s_ready = 1 while in reset and after release.
- Reset mid-group discards all partial sums and in-flight elements. The next accepted element starts a new group.
- Operand extension: each operand gets one extra MSB, its own sign bit if SIGNEDx=1, else 0. The product is a signed multiply of the two extended operands, P = DIN0_WIDTH+DIN1_WIDTH bits.
- Product is extended to ACC_WIDTH: sign-extended if SIGNED0|SIGNED1, else zero-extended.
- Advance: adv = !m_valid || m_ready.
  - s_ready = adv.
  - All pipeline stages and the accumulator update only when adv = 1.
  - When adv = 0, everything holds, including m_dout/m_valid.
- Transfer occurs when s_valid && s_ready. The product, valid and last bits enter stage 1. A non-transferring cycle with adv = 1 inserts a bubble (valid = 0).
- Tail stage = stage NUM_STAGE. On adv with tail valid:
  - acc_next = (first ? 0 : acc) + prod_ext;
  - ovf_next = (first ? 0 : ovf_sticky) | overflow of that add.
  - Overflow rule: carry-out if unsigned mode; signed overflow (same-sign operands, differing result sign) if signed mode.
  - If tail last = 0: acc <= acc_next, ovf_sticky <= ovf_next, first <= 0.
  - If tail last = 1: m_dout <= acc_next, m_ovf <= ovf_next, m_valid <= 1, acc <= 0, first <= 1.
- On adv with tail invalid or not last: m_valid <= 0. The m_ready handshake consumes the result.
- Simultaneous consume and new result (m_valid && m_ready, and tail last valid): m_valid stays 1 and m_dout takes the new value. There is no bubble between results.
- Latency: an element accepted at cycle t with s_last=1 yields m_valid=1 at cycle t+NUM_STAGE+1, assuming no stall.
- Throughput: 1 element/cycle.
- Bubbles inside a group are allowed and do not affect the sum.
- m_dout wraps modulo 2^ACC_WIDTH; m_ovf reports the wrap.

Test Plan:
- Defaults, unsigned, one-element group: 24'hFFFFFF x 18'h3FFFF, last=1 at cycle t -> m_valid at t+3, m_dout=48'h03FF_FEFC_0001, m_ovf=0.
- SIGNED0=SIGNED1=1, group (-2,3),(4,5),(-1,-1) with last on the third element and a bubble after the first -> single result m_dout=15, m_ovf=0.
- DIN0=DIN1=4, ACC_WIDTH=9, unsigned, group (15,15)x3:
  - -> m_dout=163, m_ovf=1;
  - next group (1,1) -> m_dout=1, m_ovf=0 (sticky cleared).
- Backpressure: two one-element groups, (2,3) then (4,5), with m_ready=0 for 4 cycles:
  - -> s_ready=0 while stalled, m_dout=6 held stable;
  - after m_ready=1, m_dout=6 then m_dout=20; no loss, no duplication.
- Back-to-back: continuous one-element groups with m_ready=1 -> m_valid high every cycle, results in input order.
- Reset mid-group: accept (3,3),(2,2) without last, pulse ap_rst_n low asynchronously, then group (7,6) last -> m_dout=42. Outputs are 0 during reset.
